// File: rtl/arb_pkg.sv
// Shared types for the data-memory arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    S_CPU     = 2'd0,
    S_EXT     = 2'd1,
    S_HANDOFF = 2'd2
  } arbState_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between core, external requester and data memory.
// slave: the arbiter's view; master: the surrounding system's view.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              ext_valid;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_last;
  logic              ext_ready;
  logic [DATA_W-1:0] ext_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              ext_owns;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  ext_valid, ext_we, ext_addr, ext_wdata, ext_last,
    output ext_ready, ext_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output ext_owns
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output ext_valid, ext_we, ext_addr, ext_wdata, ext_last,
    input  ext_ready, ext_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  ext_owns
  );

endinterface

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the core load/store path
// and an external burst requester, bounding core starvation during bursts.
module dmem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input logic           clk,
  input logic           areset,
  dmem_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD - 1);

  arbState_t         state;
  arbState_t         nextState;
  logic [CNT_W-1:0]  holdCnt;
  logic [CNT_W-1:0]  nextHold;
  logic              cpuGrant;
  logic              extGrant;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;

  // State and hold counter register
  always_ff @(posedge clk) begin
    if (areset) begin
      state   <= S_CPU;
      holdCnt <= '0;
    end else begin
      state   <= nextState;
      holdCnt <= nextHold;
    end
  end

  // Grant decision, next state and hold counter update
  always_comb begin
    nextState = state;
    nextHold  = holdCnt;
    cpuGrant  = 1'b0;
    extGrant  = 1'b0;
    case (state)
      S_CPU: begin
        if (bus.cpu_req) begin
          cpuGrant = 1'b1;
        end else if (bus.ext_valid) begin
          extGrant = 1'b1;
          nextHold = '0;
          if (!bus.ext_last) nextState = S_EXT;
        end
      end
      S_EXT: begin
        if (bus.ext_valid) extGrant = 1'b1;
        else               cpuGrant = bus.cpu_req;
        // Burst end beats the handoff; otherwise count stalled cycles.
        if (bus.ext_valid && bus.ext_last) begin
          nextState = S_CPU;
          nextHold  = '0;
        end else if (bus.cpu_req && !cpuGrant) begin
          if (holdCnt == HOLD_LIMIT) begin
            nextState = S_HANDOFF;
            nextHold  = '0;
          end else begin
            nextHold = holdCnt + CNT_W'(1);
          end
        end else begin
          nextHold = '0;
        end
      end
      S_HANDOFF: begin
        cpuGrant  = bus.cpu_req;
        nextState = S_EXT;
        nextHold  = '0;
      end
      default: begin
        nextState = S_CPU;
        nextHold  = '0;
      end
    endcase
  end

  // Memory port mux driven by the granted requester
  always_comb begin
    memWe    = 1'b0;
    memAddr  = '0;
    memWdata = '0;
    if (cpuGrant) begin
      memWe    = bus.cpu_we;
      memAddr  = bus.cpu_addr;
      memWdata = bus.cpu_wdata;
    end else if (extGrant) begin
      memWe    = bus.ext_we;
      memAddr  = bus.ext_addr;
      memWdata = bus.ext_wdata;
    end
  end

  assign bus.mem_we    = memWe & ~areset;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_wdata = memWdata;
  assign bus.ext_ready = extGrant & ~areset;
  assign bus.cpu_stall = bus.cpu_req & ~cpuGrant & ~areset;
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.ext_rdata = bus.mem_rdata;
  assign bus.ext_owns  = (state != S_CPU);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a burst-level reference model.
module tb_dmem_arbiter;

  localparam int MAXH = 8;

  logic clk;
  logic areset;
  logic [31:0] memArr [0:255];

  int checks = 0;
  int errors = 0;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .MAX_HOLD(MAXH),
    .CNT_W   (4)
  ) dut (
    .clk   (clk),
    .areset(areset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side memory: combinational read, write on rising edge
  assign bus.mem_rdata = memArr[bus.mem_addr[7:0]];
  always @(posedge clk) if (bus.mem_we) memArr[bus.mem_addr[7:0]] <= bus.mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a burst is either open or not; while open, the external
  // side wins, and after MAX_HOLD consecutive stalled cycles the core gets one
  // guaranteed cycle.
  bit mBurst = 0;
  bit mHandoff = 0;
  int mRun = 0;

  always @(negedge clk) begin
    bit cG, eG, st, xfer;
    logic [31:0] eAddr, eData;
    logic eWe;
    if (mHandoff) begin
      cG = bus.cpu_req; eG = 0;
    end else if (mBurst) begin
      eG = bus.ext_valid; cG = !bus.ext_valid && bus.cpu_req;
    end else begin
      cG = bus.cpu_req; eG = !bus.cpu_req && bus.ext_valid;
    end
    st    = bus.cpu_req && !cG;
    eWe   = cG ? bus.cpu_we : (eG ? bus.ext_we : 1'b0);
    eAddr = cG ? bus.cpu_addr : (eG ? bus.ext_addr : 32'd0);
    eData = cG ? bus.cpu_wdata : (eG ? bus.ext_wdata : 32'd0);
    if (areset) begin
      chk("rstMemWe", {31'd0, bus.mem_we}, 32'd0);
      chk("rstReady", {31'd0, bus.ext_ready}, 32'd0);
      chk("rstStall", {31'd0, bus.cpu_stall}, 32'd0);
    end else begin
      chk("memWe", {31'd0, bus.mem_we}, {31'd0, eWe});
      chk("memAddr", bus.mem_addr, eAddr);
      chk("memWdata", bus.mem_wdata, eData);
      chk("extReady", {31'd0, bus.ext_ready}, {31'd0, eG});
      chk("cpuStall", {31'd0, bus.cpu_stall}, {31'd0, st});
      chk("extOwns", {31'd0, bus.ext_owns}, {31'd0, mBurst});
      chk("cpuRdata", bus.cpu_rdata, memArr[eAddr[7:0]]);
      chk("extRdata", bus.ext_rdata, memArr[eAddr[7:0]]);
    end
    xfer = eG;
    if (areset) begin
      mBurst = 0; mHandoff = 0; mRun = 0;
    end else if (mHandoff) begin
      mHandoff = 0; mRun = 0;
    end else if (mBurst) begin
      if (xfer && bus.ext_last) begin
        mBurst = 0; mRun = 0;
      end else if (st) begin
        mRun++;
        if (mRun == MAXH) begin
          mHandoff = 1; mRun = 0;
        end
      end else begin
        mRun = 0;
      end
    end else if (xfer && !bus.ext_last) begin
      mBurst = 1;
    end
  end

  // External inputs must stay put while a beat waits for acceptance
  logic pendPrev = 1'b0;
  logic [97:0] extPrev;
  always @(posedge clk) begin
    if (pendPrev)
      chk("extStable", {31'd0, extPrev === {bus.ext_we, bus.ext_last, bus.ext_addr, bus.ext_wdata}}, 32'd1);
    pendPrev <= bus.ext_valid && !bus.ext_ready && !areset;
    extPrev  <= {bus.ext_we, bus.ext_last, bus.ext_addr, bus.ext_wdata};
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic runBurst(input int n, input logic [31:0] base, input logic we,
                          input logic cpuAfter, output int cycles, output int readyCnt,
                          output int stallCnt, output int ownsCnt);
    int beat = 0;
    logic acc;
    cycles = 0; readyCnt = 0; stallCnt = 0; ownsCnt = 0;
    bus.cpu_req = 1'b0;
    while (beat < n && cycles < 200) begin
      bus.ext_valid = 1'b1;
      bus.ext_we    = we;
      bus.ext_addr  = base + 32'(4 * beat);
      bus.ext_wdata = 32'h1000 + 32'(beat);
      bus.ext_last  = (beat == n - 1);
      @(negedge clk);
      acc = bus.ext_ready;
      if (bus.ext_ready) readyCnt++;
      if (bus.cpu_stall) stallCnt++;
      if (bus.ext_owns) ownsCnt++;
      cycles++;
      cycle();
      if (acc) begin
        beat++;
        bus.cpu_req = cpuAfter;
      end
    end
    bus.ext_valid = 1'b0;
    bus.ext_last  = 1'b0;
    bus.cpu_req   = 1'b0;
    if (cycles >= 200) chk("burstTimeout", 32'(cycles), 32'(n));
  endtask

  initial begin
    int cyc, rdy, stl, own;
    for (int i = 0; i < 256; i++) memArr[i] = 32'hC0DE_0000 | 32'(i);

    // Reset with both requesters active
    areset = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h4; bus.cpu_wdata = 32'h55;
    bus.ext_valid = 1'b1; bus.ext_we = 1'b1; bus.ext_addr = 32'h8;
    bus.ext_wdata = 32'h66; bus.ext_last = 1'b0;
    cycle();
    cycle();
    areset = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.ext_valid = 1'b0; bus.ext_we = 1'b0;
    @(negedge clk);
    chk("rstOwns", {31'd0, bus.ext_owns}, 32'd0);
    chk("rstIdleWe", {31'd0, bus.mem_we}, 32'd0);
    cycle();

    // Core store wins against a waiting single ext read
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h10; bus.cpu_wdata = 32'hAA;
    bus.ext_valid = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = 32'h20; bus.ext_last = 1'b1;
    bus.ext_wdata = 32'h0;
    @(negedge clk);
    chk("prioAddr", bus.mem_addr, 32'h10);
    chk("prioReady", {31'd0, bus.ext_ready}, 32'd0);
    cycle();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    @(negedge clk);
    chk("memWritten", memArr[8'h10], 32'hAA);
    chk("singleReady", {31'd0, bus.ext_ready}, 32'd1);
    chk("singleRdata", bus.ext_rdata, 32'hC0DE_0020);
    cycle();
    bus.ext_valid = 1'b0; bus.ext_last = 1'b0;
    @(negedge clk);
    chk("singleOwns", {31'd0, bus.ext_owns}, 32'd0);
    cycle();

    // Uncontended 4-beat write burst
    runBurst(4, 32'h40, 1'b1, 1'b0, cyc, rdy, stl, own);
    chk("burst4Cycles", 32'(cyc), 32'd4);
    chk("burst4Ready", 32'(rdy), 32'd4);
    chk("burst4Owns", 32'(own), 32'd3);
    @(negedge clk);
    chk("burst4Last", memArr[8'h4C], 32'h1003);
    chk("burst4Done", {31'd0, bus.ext_owns}, 32'd0);
    cycle();

    // 20-beat burst against a continuously requesting core
    bus.cpu_we = 1'b0; bus.cpu_addr = 32'h10;
    runBurst(20, 32'h80, 1'b1, 1'b1, cyc, rdy, stl, own);
    chk("starveCycles", 32'(cyc), 32'd22);
    chk("starveStalls", 32'(stl), 32'd19);
    chk("starveHandoffs", 32'(cyc - rdy), 32'd2);
    cycle();

    // Bubble inside a burst, then reset mid-burst
    bus.cpu_req = 1'b0;
    bus.ext_valid = 1'b1; bus.ext_we = 1'b1; bus.ext_addr = 32'h50;
    bus.ext_wdata = 32'h77; bus.ext_last = 1'b0;
    cycle();
    bus.ext_valid = 1'b0; bus.cpu_req = 1'b1; bus.cpu_addr = 32'h20;
    @(negedge clk);
    chk("bubbleStall", {31'd0, bus.cpu_stall}, 32'd0);
    chk("bubbleOwns", {31'd0, bus.ext_owns}, 32'd1);
    chk("bubbleAddr", bus.mem_addr, 32'h20);
    cycle();
    bus.ext_valid = 1'b1; bus.ext_addr = 32'h54; bus.ext_wdata = 32'h78;
    @(negedge clk);
    chk("beat2Stall", {31'd0, bus.cpu_stall}, 32'd1);
    chk("beat2Ready", {31'd0, bus.ext_ready}, 32'd1);
    cycle();
    areset = 1'b1;
    cycle();
    areset = 1'b0; bus.ext_valid = 1'b0; bus.cpu_req = 1'b0; bus.ext_we = 1'b0;
    @(negedge clk);
    chk("midRstOwns", {31'd0, bus.ext_owns}, 32'd0);
    cycle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the single-cycle core's load/store path and an external requester (program loader / debug / DMA).
- Sits between the core datapath and `data_mem_module`.
- Drives a stall that the top level ties to the program counter `load` input and to the RegWrite/MemWrite gating.
- Core has priority except during an external burst, where a hold counter bounds core starvation.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_HOLD, 8, max consecutive cycles core may be stalled by a burst before forced handoff; legal range 1..15
- CNT_W, 4, hold counter width; must satisfy 2^CNT_W > MAX_HOLD

Ports:
- clk  in  1  system clock, rising edge
- areset  in  1  reset, synchronous, active-high
- cpu_req  in  1  core instruction this cycle is a load or store
- cpu_we  in  1  core store
- cpu_addr  in  ADDR_W  core address (ALUResult)
- cpu_wdata  in  DATA_W  core store data
- cpu_rdata  out  DATA_W  load data to core
- cpu_stall  out  1  core must hold PC and suppress writeback this cycle
- ext_valid  in  1  external beat valid
- ext_we  in  1  external write
- ext_addr  in  ADDR_W  external address
- ext_wdata  in  DATA_W  external write data
- ext_last  in  1  final beat of burst
- ext_ready  out  1  beat accepted this cycle (transfer = ext_valid & ext_ready)
- ext_rdata  out  DATA_W  external read data, valid in transfer cycle
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory combinational read data
- ext_owns  out  1  status: FSM in S_EXT or S_HANDOFF

Behaviour:
- Memory model: combinational read, write on rising edge. All grants are combinational from state and inputs; zero-latency transfer.
- State register and hold_cnt are updated on the rising clk edge. When areset is high: next state = S_CPU, hold_cnt = 0.
- Output gating while areset is high: mem_we=0, ext_ready=0, cpu_stall=0.
- cpu_rdata = ext_rdata = mem_rdata, unconditionally.
- Granted requester drives mem_addr/mem_wdata. mem_we = granted.we & granted request.
- With no grant: mem_addr=0, mem_wdata=0, mem_we=0.
- cpu_stall = cpu_req & ~cpu_grant.
- S_CPU (reset state):
  - cpu_req=1: grant core; ext_ready=0.
  - Else ext_valid=1: grant ext; ext_ready=1. If ext_last=0, go to S_EXT with hold_cnt=0. If ext_last=1 (single beat), stay in S_CPU.
  - Else idle.
- S_EXT (burst open):
  - ext_valid=1: grant ext; ext_ready=1. A pending cpu_req stalls. If ext_last=1, go to S_CPU with hold_cnt=0.
  - ext_valid=0 (bubble): grant core if cpu_req, no stall.
  - Each cycle with cpu_stall=1: hold_cnt+1. Any cycle with cpu_stall=0: hold_cnt=0.
  - When cpu_stall=1, hold_cnt==MAX_HOLD-1 and ext_last=0: go to S_HANDOFF, hold_cnt=0.
  - ext_last takes precedence over handoff (go to S_CPU).
- S_HANDOFF (exactly one cycle):
  - ext_ready=0; grant core if cpu_req.
  - Next state S_EXT; the burst remains open.
- Simultaneous cpu_req and ext_valid:
  - S_CPU: core wins.
  - S_EXT: ext wins.
  - S_HANDOFF: core wins.
- Reset mid-burst: FSM returns to S_CPU. Any partial burst is abandoned; the external side restarts it.
- ext_* inputs must be held stable while ext_valid=1 and ext_ready=0; assertion in bench.

Decomposition:
- Shared package `arb_pkg`: state encoding constants S_CPU=2'd0, S_EXT=2'd1, S_HANDOFF=2'd2.
- Single module, no sub-module. Hold counter and mux are inline (~150 lines RTL).

Test Plan:
- Reset: areset=1 for 2 cycles with cpu_req=1, ext_valid=1 → mem_we=0, ext_ready=0, cpu_stall=0, ext_owns=0 after release.
- Core priority: S_CPU, cpu_req=1 cpu_we=1 addr=0x10 wdata=0xAA, ext_valid=1 → mem_addr=0x10, mem_we=1, ext_ready=0, cpu_stall=0; memory[0x10]=0xAA next edge.
- Single ext beat: cpu_req=0, ext_valid=1 ext_last=1 ext_we=0 addr=0x20 → ext_ready=1, ext_rdata=mem[0x20], state remains S_CPU.
- Burst of 4 writes 0x40..0x4C with cpu_req=0 → 4 consecutive ext_ready cycles, ext_owns=1 beats 2–4, back to S_CPU after ext_last.
- Starvation: MAX_HOLD=8, 20-beat burst, cpu_req held 1 → cpu_stall=1 for 8 cycles, then one S_HANDOFF cycle (ext_ready=0, core granted), repeat; burst completes in 22 cycles.
- Bubble + reset: in S_EXT, ext_valid=0 with cpu_req=1 → core granted, cpu_stall=0, hold_cnt=0. Then areset mid-burst → S_CPU next cycle, ext_owns=0.
